vc_fifo: RTL

VC_FIFO -- requirements
Module: vc_fifo

---
 rtl/vc_fifo_pkg.sv | 12 +
 rtl/vc_fifo_lane.sv | 50 +++++
 rtl/vc_fifo.sv | 82 ++++++++
 3 files changed

// File: rtl/vc_fifo_pkg.sv
// vc_fifo_pkg: default sizes and width helpers shared by vc_fifo and its lanes.
package vc_fifo_pkg;
  localparam int DEF_DATA_W = 64;
  localparam int DEF_DEPTH = 16;
  localparam int DEF_NUM_VC = 4;
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction
  function automatic int ocup_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/vc_fifo_lane.sv
// vc_fifo_lane: one single-channel queue; push/pop arrive already qualified by the parent.
module vc_fifo_lane
  import vc_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          din,
  output logic [DATA_W-1:0]          head,
  output logic [ocup_w(DEPTH)-1:0]   ocup,
  output logic                       full,
  output logic                       almost_full,
  output logic                       empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int OW = ocup_w(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OW-1:0] ocup_q, ocup_d;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    ocup_d = ocup_q + OW'(push) - OW'(pop);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ocup_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ocup_q <= ocup_d;
    end
  end
  // Storage is deliberately left out of reset; occupancy alone defines validity.
  always_ff @(posedge clk) begin
    if (push && !reset) mem_q[wr_ptr_q] <= din;
  end
  assign head = mem_q[rd_ptr_q];
  assign ocup = ocup_q;
  assign full = ocup_q == OW'(DEPTH);
  assign empty = ocup_q == '0;
  assign almost_full = ocup_q >= OW'(AFULL_TH);
endmodule

// File: rtl/vc_fifo.sv
// vc_fifo: NUM_VC independent FIFOs with shared write/read ports and sticky error flags.
// Define VC_FIFO_FWFT_EN for first-word-fall-through reads; default is one-cycle registered read.
module vc_fifo
  import vc_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int NUM_VC = DEF_NUM_VC,
  parameter int AFULL_TH = DEPTH - 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              write_en,
  input  logic [$clog2(NUM_VC)-1:0]         wr_vc,
  input  logic [DATA_W-1:0]                 data_in,
  input  logic                              read_en,
  input  logic [$clog2(NUM_VC)-1:0]         rd_vc,
  output logic [DATA_W-1:0]                 data_out,
  output logic                              rd_valid,
  output logic [NUM_VC-1:0]                 full,
  output logic [NUM_VC-1:0]                 almost_full,
  output logic [NUM_VC-1:0]                 empty,
  output logic [NUM_VC*ocup_w(DEPTH)-1:0]   ocup,
  output logic                              error,
  output logic [NUM_VC-1:0]                 err_vc
);
  localparam int OW = ocup_w(DEPTH);
  logic [DATA_W-1:0] heads [NUM_VC];
  logic [NUM_VC-1:0] push, pop, err_vc_q, err_vc_d;
  logic rd_ok, wr_ok, wr_rej, rd_rej, error_q, error_d;
  always_comb begin
    rd_ok = read_en && !empty[rd_vc];
    // A full VC still takes a write when the same VC is popped in this cycle.
    wr_ok = write_en && (!full[wr_vc] || (rd_ok && rd_vc == wr_vc));
    wr_rej = write_en && !wr_ok;
    rd_rej = read_en && !rd_ok;
    push = wr_ok ? NUM_VC'(1) << wr_vc : '0;
    pop = rd_ok ? NUM_VC'(1) << rd_vc : '0;
    error_d = error_q | wr_rej | rd_rej;
    err_vc_d = err_vc_q | (wr_rej ? NUM_VC'(1) << wr_vc : '0) | (rd_rej ? NUM_VC'(1) << rd_vc : '0);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
      err_vc_q <= '0;
    end else begin
      error_q <= error_d;
      err_vc_q <= err_vc_d;
    end
  end
  assign error = error_q;
  assign err_vc = err_vc_q;
  for (genvar i = 0; i < NUM_VC; i++) begin : g_lane
    vc_fifo_lane #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) u_lane (
      .clk(clk), .reset(reset), .push(push[i]), .pop(pop[i]), .din(data_in),
      .head(heads[i]), .ocup(ocup[i*OW +: OW]), .full(full[i]),
      .almost_full(almost_full[i]), .empty(empty[i])
    );
  end
`ifdef VC_FIFO_FWFT_EN
  assign data_out = heads[rd_vc];
  assign rd_valid = !empty[rd_vc];
`else
  logic [DATA_W-1:0] data_out_q, data_out_d;
  logic rd_valid_q, rd_valid_d;
  always_comb begin
    data_out_d = rd_ok ? heads[rd_vc] : data_out_q;
    rd_valid_d = rd_ok;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
    end
  end
  assign data_out = data_out_q;
  assign rd_valid = rd_valid_q;
`endif
endmodule
